// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle control unit for a small accumulator CPU.
// It fetches 9-bit instructions from a ROM with a one-cycle read latency,
// decodes them into ALU, register-file and data-memory controls, keeps the
// program counter and carry flag, and stops in DONE on HALT.
module ctrl_sequencer (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       start,
  input  logic [8:0] inst_in,
  input  logic       branch_en,
  input  logic       sc_out,
  input  logic       zero,
  output logic [7:0] inst_addr,
  output logic [3:0] alu_op,
  output logic       reg_exe,
  output logic       imm_exe,
  output logic       reg_to_acc,
  output logic       acc_to_reg,
  output logic       sc_in,
  output logic [7:0] imm_out,
  output logic [3:0] reg_sel,
  output logic       acc_we,
  output logic       reg_we,
  output logic       mem_re,
  output logic       mem_we,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_BEQ    = 4'd2,
    OP_SL     = 4'd3,
    OP_SR     = 4'd4,
    OP_LW     = 4'd5,
    OP_SW     = 4'd6,
    OP_MOV    = 4'd7,
    OP_ASSIGN = 4'd8,
    OP_BGE    = 4'd9,
    OP_BNE    = 4'd10,
    OP_AND    = 4'd11,
    OP_OR     = 4'd12,
    OP_NOP    = 4'd13,
    OP_JMP    = 4'd14,
    OP_HALT   = 4'd15
  } opcode_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_pc;
  logic [7:0] w_next_pc;
  logic       r_carry;
  logic       w_next_carry;

  opcode_t    w_op;
  logic       w_mode_reg;
  logic [7:0] w_jmp_ofs;
  logic       w_unused_zero;

  // The zero flag is only consumed by the ALU's own branch_en logic.
  assign w_unused_zero = zero;

  assign w_op       = opcode_t'(inst_in[8:5]);
  assign w_mode_reg = inst_in[4];
  // JMP offset is a signed 5-bit field; 8-bit wrap gives modulo-256 PC math.
  assign w_jmp_ofs  = {{3{inst_in[4]}}, inst_in[4:0]};
  assign inst_addr  = r_pc;

  // State, program counter and carry flag registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pc    <= 8'd0;
      r_carry <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_carry <= w_next_carry;
    end
  end

  // Next-state, next-PC and carry-load logic.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_carry = r_carry;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_FETCH;
          w_next_pc    = 8'd0;
        end
      end

      S_FETCH: begin
        w_next_state = S_EXEC;
      end

      S_EXEC: begin
        w_next_state = S_FETCH;
        case (w_op)
          OP_LW: begin
            // PC advances in MEM, once the load has completed.
            w_next_state = S_MEM;
          end
          OP_HALT: begin
            w_next_state = S_DONE;
          end
          OP_BEQ, OP_BGE, OP_BNE: begin
            w_next_pc = r_pc + (branch_en ? 8'd2 : 8'd1);
          end
          OP_JMP: begin
            w_next_pc = r_pc + w_jmp_ofs;
          end
          default: begin
            w_next_pc = r_pc + 8'd1;
          end
        endcase

        if (w_op == OP_ADD || w_op == OP_SUB || w_op == OP_SL || w_op == OP_SR) begin
          w_next_carry = sc_out;
        end
      end

      S_MEM: begin
        w_next_state = S_FETCH;
        w_next_pc    = r_pc + 8'd1;
      end

      S_DONE: begin
        if (start) begin
          w_next_state = S_FETCH;
          w_next_pc    = 8'd0;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Control decode: active only while the fetched word is valid (EXEC/MEM).
  always_comb begin
    alu_op     = 4'd0;
    reg_exe    = 1'b0;
    imm_exe    = 1'b0;
    reg_to_acc = 1'b0;
    acc_to_reg = 1'b0;
    sc_in      = 1'b0;
    imm_out    = 8'd0;
    reg_sel    = 4'd0;
    acc_we     = 1'b0;
    reg_we     = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    // done rises as soon as HALT is decoded and holds through DONE.
    done       = (r_state == S_DONE) || (r_state == S_EXEC && w_op == OP_HALT);

    if (r_state == S_EXEC || r_state == S_MEM) begin
      alu_op  = inst_in[8:5];
      reg_exe = w_mode_reg;
      imm_exe = ~w_mode_reg;
      imm_out = {4'b0000, inst_in[3:0]};
      reg_sel = inst_in[3:0];
      sc_in   = r_carry;
    end

    if (r_state == S_EXEC) begin
      case (w_op)
        OP_ADD, OP_SUB, OP_SL, OP_SR, OP_AND, OP_OR, OP_ASSIGN: begin
          acc_we = 1'b1;
        end
        OP_MOV: begin
          if (w_mode_reg) begin
            reg_to_acc = 1'b1;
            acc_we     = 1'b1;
          end else begin
            acc_to_reg = 1'b1;
            reg_we     = 1'b1;
          end
        end
        OP_SW: begin
          mem_we = 1'b1;
        end
        OP_LW: begin
          mem_re = 1'b1;
        end
        default: begin
        end
      endcase
    end

    if (r_state == S_MEM) begin
      // Second LW cycle: read data is on the bus, write it to the accumulator.
      mem_re = 1'b1;
      acc_we = 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed per-cycle stimulus with hand-computed expected
// outputs pushed to a scoreboard queue; a monitor pops and compares each cycle.
module tb_ctrl_sequencer;

  logic       CLK;
  logic       Reset;
  logic       start;
  logic [8:0] inst_in;
  logic       branch_en;
  logic       sc_out;
  logic       zero;
  logic [7:0] inst_addr;
  logic [3:0] alu_op;
  logic       reg_exe;
  logic       imm_exe;
  logic       reg_to_acc;
  logic       acc_to_reg;
  logic       sc_in;
  logic [7:0] imm_out;
  logic [3:0] reg_sel;
  logic       acc_we;
  logic       reg_we;
  logic       mem_re;
  logic       mem_we;
  logic       done;

  // Snapshot layout: {inst_addr[7:0], en[5:0], done, sc_in, alu_op[3:0]}
  // en = {acc_we, reg_we, mem_re, mem_we, reg_to_acc, acc_to_reg}
  typedef struct {
    string       name;
    logic [19:0] vec;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ctrl_sequencer dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .start      (start),
    .inst_in    (inst_in),
    .branch_en  (branch_en),
    .sc_out     (sc_out),
    .zero       (zero),
    .inst_addr  (inst_addr),
    .alu_op     (alu_op),
    .reg_exe    (reg_exe),
    .imm_exe    (imm_exe),
    .reg_to_acc (reg_to_acc),
    .acc_to_reg (acc_to_reg),
    .sc_in      (sc_in),
    .imm_out    (imm_out),
    .reg_sel    (reg_sel),
    .acc_we     (acc_we),
    .reg_we     (reg_we),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .done       (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [19:0] snap();
    return {inst_addr, acc_we, reg_we, mem_re, mem_we, reg_to_acc, acc_to_reg,
            done, sc_in, alu_op};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got addr=%0d en=%b done=%b sc=%b op=%0d, expected addr=%0d en=%b done=%b sc=%b op=%0d",
               name, act[19:12], act[11:6], act[5], act[4], act[3:0],
               exp[19:12], exp[11:6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic step(input string nm, input bit rst, input bit st, input logic [8:0] ins,
                      input bit br, input bit sco, input logic [7:0] a, input logic [5:0] en,
                      input bit d, input bit sc, input logic [3:0] op);
    exp_t e;
    @(posedge CLK);
    #1;
    Reset     = rst;
    start     = st;
    inst_in   = ins;
    branch_en = br;
    sc_out    = sco;
    e.name    = nm;
    e.vec     = {a, en, d, sc, op};
    q.push_back(e);
  endtask

  // Monitor: the DUT presents a fresh control word every cycle; compare it
  // mid-cycle against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check(e.name, snap(), e.vec);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [5:0] N   = 6'b000000;
  localparam logic [5:0] ACC = 6'b100000;
  localparam logic [5:0] RWE = 6'b010001;
  localparam logic [5:0] RTA = 6'b100010;
  localparam logic [5:0] RE  = 6'b001000;
  localparam logic [5:0] WE  = 6'b000100;
  localparam logic [5:0] LDM = 6'b101000;

  initial begin
    Reset = 1'b1; start = 1'b0; inst_in = 9'd0; branch_en = 1'b0; sc_out = 1'b0; zero = 1'b0;
    repeat (2) @(posedge CLK);

    //    name         rst st inst    br sco addr en  done sc op
    step("reset",      1, 0, 9'h000, 0, 0,  8'd0,  N,   0, 0, 4'd0);
    step("idle_hold",  0, 0, 9'h000, 0, 0,  8'd0,  N,   0, 0, 4'd0);
    step("idle_start", 0, 1, 9'h000, 0, 0,  8'd0,  N,   0, 0, 4'd0);
    step("fetch0",     0, 0, 9'h000, 0, 0,  8'd0,  N,   0, 0, 4'd0);
    step("assign5",    0, 0, 9'h105, 0, 0,  8'd0,  ACC, 0, 0, 4'd8);
    step("fetch1",     0, 0, 9'h000, 0, 0,  8'd1,  N,   0, 0, 4'd0);
    step("halt_exec",  0, 0, 9'h1E0, 0, 0,  8'd1,  N,   1, 0, 4'd15);
    step("done_hold",  0, 0, 9'h000, 0, 0,  8'd1,  N,   1, 0, 4'd0);
    step("done_start", 0, 1, 9'h000, 0, 0,  8'd1,  N,   1, 0, 4'd0);
    step("restart_f0", 0, 0, 9'h000, 0, 0,  8'd0,  N,   0, 0, 4'd0);
    step("jmp_p10",    0, 0, 9'h1CA, 0, 0,  8'd0,  N,   0, 0, 4'd14);
    step("fetch10",    0, 0, 9'h000, 0, 0,  8'd10, N,   0, 0, 4'd0);
    step("beq_taken",  0, 0, 9'h040, 1, 0,  8'd10, N,   0, 0, 4'd2);
    step("fetch12",    0, 0, 9'h000, 0, 0,  8'd12, N,   0, 0, 4'd0);
    step("jmp_m2",     0, 0, 9'h1DE, 0, 0,  8'd12, N,   0, 0, 4'd14);
    step("fetch10b",   0, 0, 9'h000, 0, 0,  8'd10, N,   0, 0, 4'd0);
    step("beq_not",    0, 0, 9'h040, 0, 0,  8'd10, N,   0, 0, 4'd2);
    step("fetch11",    0, 0, 9'h000, 0, 0,  8'd11, N,   0, 0, 4'd0);
    step("add_c1",     0, 0, 9'h013, 0, 1,  8'd11, ACC, 0, 0, 4'd0);
    step("fetch12b",   0, 0, 9'h000, 0, 0,  8'd12, N,   0, 0, 4'd0);
    step("and_keep_c", 0, 0, 9'h16F, 0, 0,  8'd12, ACC, 0, 1, 4'd11);
    step("fetch13_st", 0, 1, 9'h000, 0, 0,  8'd13, N,   0, 0, 4'd0);
    step("sl_sc_in",   0, 1, 9'h061, 0, 0,  8'd13, ACC, 0, 1, 4'd3);
    step("fetch14",    0, 0, 9'h000, 0, 0,  8'd14, N,   0, 0, 4'd0);
    step("sr_c0",      0, 0, 9'h080, 0, 0,  8'd14, ACC, 0, 0, 4'd4);
    step("fetch15",    0, 0, 9'h000, 0, 0,  8'd15, N,   0, 0, 4'd0);
    step("mov_r2a",    0, 0, 9'h0F2, 0, 0,  8'd15, RTA, 0, 0, 4'd7);
    step("fetch16",    0, 0, 9'h000, 0, 0,  8'd16, N,   0, 0, 4'd0);
    step("mov_a2r",    0, 0, 9'h0E2, 0, 0,  8'd16, RWE, 0, 0, 4'd7);
    step("fetch17",    0, 0, 9'h000, 0, 0,  8'd17, N,   0, 0, 4'd0);
    step("sw",         0, 0, 9'h0D1, 0, 0,  8'd17, WE,  0, 0, 4'd6);
    step("fetch18",    0, 0, 9'h000, 0, 0,  8'd18, N,   0, 0, 4'd0);
    step("jmp_m15",    0, 0, 9'h1D1, 0, 0,  8'd18, N,   0, 0, 4'd14);
    step("fetch3",     0, 0, 9'h000, 0, 0,  8'd3,  N,   0, 0, 4'd0);
    step("lw_exec",    0, 1, 9'h0A0, 0, 0,  8'd3,  RE,  0, 0, 4'd5);
    step("lw_mem",     0, 1, 9'h0A0, 0, 0,  8'd3,  LDM, 0, 0, 4'd5);
    step("fetch4",     0, 0, 9'h000, 0, 0,  8'd4,  N,   0, 0, 4'd0);
    step("jmp_m3",     0, 0, 9'h1DD, 0, 0,  8'd4,  N,   0, 0, 4'd14);
    step("fetch1b",    0, 0, 9'h000, 0, 0,  8'd1,  N,   0, 0, 4'd0);
    step("jmp_m2_wrap",0, 0, 9'h1DE, 0, 0,  8'd1,  N,   0, 0, 4'd14);
    step("fetch255",   0, 0, 9'h000, 0, 0,  8'd255,N,   0, 0, 4'd0);
    step("nop_255",    0, 0, 9'h1A0, 0, 0,  8'd255,N,   0, 0, 4'd13);
    step("fetch0_wrap",0, 0, 9'h000, 0, 0,  8'd0,  N,   0, 0, 4'd0);
    step("jmp_to_254", 0, 0, 9'h1DE, 0, 0,  8'd0,  N,   0, 0, 4'd14);
    step("fetch254",   0, 0, 9'h000, 0, 0,  8'd254,N,   0, 0, 4'd0);
    step("bge_254",    0, 0, 9'h120, 1, 0,  8'd254,N,   0, 0, 4'd9);
    step("fetch0_bge", 0, 0, 9'h000, 0, 0,  8'd0,  N,   0, 0, 4'd0);
    step("jmp_p5",     0, 0, 9'h1C5, 0, 0,  8'd0,  N,   0, 0, 4'd14);
    step("fetch5",     0, 0, 9'h000, 0, 0,  8'd5,  N,   0, 0, 4'd0);
    step("add_set_c",  0, 0, 9'h001, 0, 1,  8'd5,  ACC, 0, 0, 4'd0);
    step("fetch6",     0, 0, 9'h000, 0, 0,  8'd6,  N,   0, 0, 4'd0);
    step("sw_pre_rst", 0, 1, 9'h0D1, 0, 0,  8'd6,  WE,  0, 1, 4'd6);

    // Assert Reset asynchronously in the middle of the SW execute cycle.
    @(negedge CLK);
    #2;
    Reset = 1'b1;
    #1;
    check("rst_drop", snap(), {8'd0, N, 1'b0, 1'b0, 4'd0});

    step("rst_hold",   1, 1, 9'h0D1, 0, 0,  8'd0,  N,   0, 0, 4'd0);
    step("rst_release",0, 0, 9'h000, 0, 0,  8'd0,  N,   0, 0, 4'd0);
    step("post_idle",  0, 0, 9'h000, 0, 0,  8'd0,  N,   0, 0, 4'd0);
    step("post_start", 0, 1, 9'h000, 0, 0,  8'd0,  N,   0, 0, 4'd0);
    step("post_f0",    0, 0, 9'h000, 0, 0,  8'd0,  N,   0, 0, 4'd0);
    step("carry_clr",  0, 0, 9'h001, 0, 0,  8'd0,  ACC, 0, 0, 4'd0);
    step("post_f1",    0, 0, 9'h000, 0, 0,  8'd1,  N,   0, 0, 4'd0);
    step("post_halt",  0, 0, 9'h1E0, 0, 0,  8'd1,  N,   1, 0, 4'd15);
    step("post_done",  0, 0, 9'h000, 0, 0,  8'd1,  N,   1, 0, 4'd0);

    repeat (2) @(posedge CLK);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left in scoreboard, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 SHALL have a single clock domain: CLK input, 1 bit, all state updates on its rising edge.
REQ-002 SHALL have Reset input, 1 bit, asynchronous, active-high, forcing the reset state of REQ-030.
REQ-003 SHALL have start input, 1 bit: begin execution from PC 0.
REQ-004 SHALL have inst_in input, 9 bits: instruction word for the inst_addr presented in the previous cycle (ROM read latency 1).
REQ-005 SHALL have the following inputs from the ALU: branch_en (1 bit), sc_out (1 bit), zero (1 bit).
REQ-006 SHALL have inst_addr output, 8 bits: program counter.
REQ-007 SHALL have the following ALU control outputs: alu_op (4 bits), reg_exe, imm_exe, reg_to_acc, acc_to_reg, sc_in (1 bit each), imm_out (8 bits).
REQ-008 SHALL have the following outputs: reg_sel (4 bits), acc_we, reg_we, mem_re, mem_we, done (1 bit each).

Function
REQ-010 Instruction format SHALL be: inst[8:5] opcode, inst[4] mode (1 = register operand, 0 = immediate), inst[3:0] register index or immediate.
REQ-011 Opcodes SHALL be: ADD=0, SUB=1, BEQ=2, SL=3, SR=4, LW=5, SW=6, MOV=7, ASSIGN=8, BGE=9, BNE=10, AND=11, OR=12, JMP=14, HALT=15; 13 is a NOP.
REQ-012 FSM states SHALL be IDLE, FETCH, EXEC, MEM, DONE.
REQ-013 IDLE SHALL go to FETCH on start=1 with pc=0; otherwise it SHALL hold.
REQ-014 FETCH SHALL present inst_addr=pc and go to EXEC next cycle.
REQ-015 EXEC: LW SHALL go to MEM; HALT SHALL go to DONE; all other opcodes SHALL go to FETCH.
REQ-016 MEM SHALL assert acc_we for one cycle, set pc=pc+1, and go to FETCH; LW therefore takes 3 cycles and all other opcodes take 2.
REQ-017 DONE SHALL hold done=1 and pc; start=1 in DONE SHALL clear done, set pc=0, and go to FETCH.
REQ-018 start SHALL be ignored in FETCH, EXEC and MEM.
REQ-019 ALU controls SHALL decode combinationally from inst_in only in EXEC and MEM; otherwise all controls SHALL be 0.
REQ-020 Decode SHALL be: alu_op=inst[8:5]; reg_exe=inst[4]; imm_exe=~inst[4]; imm_out={4'b0,inst[3:0]}; reg_sel=inst[3:0].
REQ-021 MOV SHALL be: inst[4]=1 gives reg_to_acc=1 and acc_we=1; inst[4]=0 gives acc_to_reg=1 and reg_we=1.
REQ-022 acc_we SHALL pulse in EXEC for ADD, SUB, SL, SR, AND, OR, ASSIGN and MOV(reg_to_acc).
REQ-023 SW SHALL pulse mem_we in EXEC; LW SHALL assert mem_re in both EXEC and MEM.
REQ-024 Carry flag register SHALL drive sc_in and SHALL load sc_out at the end of EXEC for ADD, SUB, SL and SR only.
REQ-025 PC update at the end of EXEC SHALL be:
  - BEQ/BGE/BNE: pc+2 if branch_en=1, else pc+1.
  - JMP: pc + sign-extended inst[4:0].
  - HALT: unchanged.
  - all others: pc+1.
REQ-026 PC arithmetic SHALL be 8-bit modulo: 255+1=0, 254+2=0, 1+(-2)=255.
REQ-027 reg_we, acc_we and mem_we SHALL never be asserted in the same cycle.

Reset
REQ-030 Reset=1 SHALL asynchronously force: state=IDLE, pc=0, carry=0, done=0, and all write/read enables to 0, including mid-instruction in EXEC or MEM.
REQ-031 After Reset deasserts, the block SHALL remain in IDLE until start=1.
REQ-032 No memory or register write SHALL occur in the cycle Reset deasserts.

Verification
REQ-040 Reset then start, ROM[0]=ASSIGN #5 (0x105), ROM[1]=HALT (0x1E0): acc_we pulses at cycle 2; done=1 from cycle 4; inst_addr holds 1.
REQ-041 BEQ at pc=10 with branch_en=1: next inst_addr=12; with branch_en=0: next inst_addr=11.
REQ-042 ADD with sc_out=1, then SL: sc_in=1 during SL EXEC; an intervening AND leaves carry unchanged.
REQ-043 LW at pc=3: mem_re high in EXEC and MEM, acc_we only in MEM, next FETCH at inst_addr=4, total 3 cycles.
REQ-044 JMP offset -2 at pc=1 gives inst_addr=255; NOP at pc=255 gives inst_addr=0.
REQ-045 Reset asserted mid-EXEC of SW: mem_we drops immediately and stays 0; pc=0; start pulsed in EXEC has no effect.
